// File: rtl/pcie_tlp_pkg.sv
// PCIe TLP constants and shared types for the transmit and receive engines:
// format/type bytes, completion status codes and the TX FSM state encoding.
package pcie_tlp_pkg;

    localparam logic [7:0] FMT_TYPE_CPLD  = 8'h4A;
    localparam logic [7:0] FMT_TYPE_MRD32 = 8'h00;
    localparam logic [7:0] FMT_TYPE_MWR32 = 8'h40;

    localparam logic [2:0] CPL_STATUS_SC  = 3'b000;
    localparam logic [2:0] CPL_STATUS_UR  = 3'b001;
    localparam logic [2:0] CPL_STATUS_CRS = 3'b010;
    localparam logic [2:0] CPL_STATUS_CA  = 3'b100;

    localparam logic [11:0] CPL_BYTE_COUNT_1DW = 12'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_CPL = 3'd1,
        ST_CPL_REL  = 3'd2,
        ST_SEND_RD  = 3'd3,
        ST_RD_REL   = 3'd4
    } tx_state_e;

    typedef enum logic {
        TLP_KIND_CPLD = 1'b0,
        TLP_KIND_MRD  = 1'b1
    } tlp_kind_e;

    // A single-DW read has no last DW, so its last byte enable must be zero.
    function automatic logic [3:0] mrd_last_be(input logic [9:0] len);
        if (len == 10'd1) begin
            return 4'h0;
        end else begin
            return 4'hF;
        end
    endfunction

endpackage

// File: rtl/tlp_hdr_build.sv
// Combinational formatter producing one 128-bit TLP beat (CplD with 1 DW
// payload, or 3DW MRd header) and its byte-enable mask, selected by kind.
module tlp_hdr_build
    import pcie_tlp_pkg::*;
(
    input  logic          kind,
    input  logic [15:0]   completer_id,
    input  logic [31:0]   reg_data,
    input  logic [2:0]    req_tc,
    input  logic          req_td,
    input  logic          req_ep,
    input  logic [1:0]    req_attr,
    input  logic [15:0]   req_rid,
    input  logic [7:0]    req_tag,
    input  logic [6:0]    req_addr,
    input  logic [29:0]   rd_addr_dw,
    input  logic [9:0]    rd_len,
    input  logic [7:0]    rd_tag,
    output logic [127:0]  beat,
    output logic [15:0]   keep
);

    // Assemble the four DWs; DW0 lands in the low 32 bits of the beat.
    always_comb begin
        beat = 128'd0;
        keep = 16'h0000;
        case (tlp_kind_e'(kind))
            TLP_KIND_CPLD: begin
                beat[31:0]   = {FMT_TYPE_CPLD, 1'b0, req_tc, 4'b0000, req_td, req_ep,
                                req_attr, 2'b00, 10'd1};
                beat[63:32]  = {completer_id, CPL_STATUS_SC, 1'b0, CPL_BYTE_COUNT_1DW};
                beat[95:64]  = {req_rid, req_tag, 1'b0, req_addr};
                beat[127:96] = reg_data;
                keep         = 16'hFFFF;
            end
            TLP_KIND_MRD: begin
                beat[31:0]   = {FMT_TYPE_MRD32, 1'b0, 3'b000, 4'b0000, 2'b00, 2'b00,
                                2'b00, rd_len};
                beat[63:32]  = {completer_id, rd_tag, mrd_last_be(rd_len), 4'hF};
                beat[95:64]  = {rd_addr_dw, 2'b00};
                beat[127:96] = 32'd0;
                keep         = 16'h0FFF;
            end
            default: begin
                beat = 128'd0;
                keep = 16'h0000;
            end
        endcase
    end

endmodule

// File: rtl/tx_engine.sv
// PCIe TX engine: single-beat CplD for register reads and MRd32 for DMA.
// Define TX_EXT_TAG_EN for an 8-bit MRd tag counter (default is 5 bits).
module tx_engine
    import pcie_tlp_pkg::*;
#(
    parameter int C_DATA_WIDTH = 128
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    output logic [C_DATA_WIDTH-1:0]   s_axis_tx_tdata,
    output logic [C_DATA_WIDTH/8-1:0] s_axis_tx_tkeep,
    output logic                      s_axis_tx_tlast,
    output logic                      s_axis_tx_tvalid,
    input  logic                      s_axis_tx_tready,
    output logic [3:0]                s_axis_tx_tuser,
    input  logic [15:0]               completer_id_i,
    input  logic                      req_compl_wd_i,
    input  logic [31:0]               tx_reg_data_i,
    input  logic [2:0]                req_tc_i,
    input  logic                      req_td_i,
    input  logic                      req_ep_i,
    input  logic [1:0]                req_attr_i,
    input  logic [15:0]               req_rid_i,
    input  logic [7:0]                req_tag_i,
    input  logic [6:0]                req_addr_i,
    output logic                      compl_done_o,
    input  logic                      rd_req_i,
    input  logic [31:0]               rd_addr_i,
    input  logic [9:0]                rd_len_i,
    output logic                      rd_req_ack_o,
    output logic [7:0]                rd_tag_o
);

`ifdef TX_EXT_TAG_EN
    localparam int TAG_W = 8;
`else
    localparam int TAG_W = 5;
`endif

    tx_state_e                 state_r;
    tx_state_e                 state_nxt_s;
    logic                      tvalid_r;
    logic [C_DATA_WIDTH-1:0]   tdata_r;
    logic [C_DATA_WIDTH/8-1:0] tkeep_r;
    logic                      compl_done_r;
    logic                      rd_req_ack_r;
    logic [7:0]                rd_tag_r;
    logic [TAG_W-1:0]          tag_r;
    logic [7:0]                tag_ext_s;
    logic                      load_s;
    logic                      acc_cpl_s;
    logic                      acc_rd_s;
    logic                      kind_s;
    logic [127:0]              hdr_beat_s;
    logic [15:0]               hdr_keep_s;
    logic                      unused_addr_s;

`ifdef TX_EXT_TAG_EN
    assign tag_ext_s = tag_r;
`else
    assign tag_ext_s = {3'b000, tag_r};
`endif

    // Byte offset bits are dropped: MRd addresses are DW-aligned.
    assign unused_addr_s = &{1'b0, rd_addr_i[1:0]};

    tlp_hdr_build u_hdr (
        .kind         (kind_s),
        .completer_id (completer_id_i),
        .reg_data     (tx_reg_data_i),
        .req_tc       (req_tc_i),
        .req_td       (req_td_i),
        .req_ep       (req_ep_i),
        .req_attr     (req_attr_i),
        .req_rid      (req_rid_i),
        .req_tag      (req_tag_i),
        .req_addr     (req_addr_i),
        .rd_addr_dw   (rd_addr_i[31:2]),
        .rd_len       (rd_len_i),
        .rd_tag       (tag_ext_s),
        .beat         (hdr_beat_s),
        .keep         (hdr_keep_s)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; the *_REL states wait for the requester to drop its level.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_compl_wd_i) begin
                    state_nxt_s = ST_SEND_CPL;
                end else if (rd_req_i) begin
                    state_nxt_s = ST_SEND_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND_CPL: begin
                if (s_axis_tx_tready) begin
                    state_nxt_s = ST_CPL_REL;
                end else begin
                    state_nxt_s = ST_SEND_CPL;
                end
            end
            ST_CPL_REL: begin
                if (!req_compl_wd_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CPL_REL;
                end
            end
            ST_SEND_RD: begin
                if (s_axis_tx_tready) begin
                    state_nxt_s = ST_RD_REL;
                end else begin
                    state_nxt_s = ST_SEND_RD;
                end
            end
            ST_RD_REL: begin
                if (!rd_req_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RD_REL;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode: beat load in IDLE, acceptance in the SEND states.
    always_comb begin
        load_s    = 1'b0;
        acc_cpl_s = 1'b0;
        acc_rd_s  = 1'b0;
        kind_s    = TLP_KIND_MRD;
        case (state_r)
            ST_IDLE: begin
                load_s = req_compl_wd_i | rd_req_i;
                if (req_compl_wd_i) begin
                    kind_s = TLP_KIND_CPLD;
                end else begin
                    kind_s = TLP_KIND_MRD;
                end
            end
            ST_SEND_CPL: acc_cpl_s = s_axis_tx_tready;
            ST_SEND_RD:  acc_rd_s  = s_axis_tx_tready;
            default: begin
                load_s    = 1'b0;
                acc_cpl_s = 1'b0;
                acc_rd_s  = 1'b0;
            end
        endcase
    end

    // Registered beat, handshake pulses and tag counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tvalid_r     <= 1'b0;
            tdata_r      <= '0;
            tkeep_r      <= '0;
            compl_done_r <= 1'b0;
            rd_req_ack_r <= 1'b0;
            rd_tag_r     <= 8'd0;
            tag_r        <= '0;
        end else begin
            compl_done_r <= acc_cpl_s;
            rd_req_ack_r <= acc_rd_s;
            if (load_s) begin
                tvalid_r <= 1'b1;
                tdata_r  <= hdr_beat_s;
                tkeep_r  <= hdr_keep_s;
            end else if (acc_cpl_s || acc_rd_s) begin
                tvalid_r <= 1'b0;
            end
            if (acc_rd_s) begin
                tag_r    <= tag_r + TAG_W'(1);
                rd_tag_r <= tag_ext_s;
            end
        end
    end

    assign s_axis_tx_tdata  = tdata_r;
    assign s_axis_tx_tkeep  = tkeep_r;
    assign s_axis_tx_tvalid = tvalid_r;
    assign s_axis_tx_tlast  = tvalid_r;
    assign s_axis_tx_tuser  = 4'b0000;
    assign compl_done_o     = compl_done_r;
    assign rd_req_ack_o     = rd_req_ack_r;
    assign rd_tag_o         = rd_tag_r;

endmodule

// File: tb/tb_tx_engine.sv
// Directed self-checking bench for tx_engine (CplD, MRd, backpressure,
// arbitration, tag wrap, reset mid-beat). Honours TX_EXT_TAG_EN.
`timescale 1ns/1ps
module tb_tx_engine;

`ifdef TX_EXT_TAG_EN
    localparam int TAG_MOD = 256;
`else
    localparam int TAG_MOD = 32;
`endif

    localparam logic [127:0] CPL_A = 128'hDEADBEEF_01000510_02000004_4A000001;
    localparam logic [127:0] CPL_B = 128'h12345678_ABCDFF7F_02000004_4A50E001;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [127:0]  tdata;
    logic [15:0]   tkeep;
    logic          tlast;
    logic          tvalid;
    logic          tready;
    logic [3:0]    tuser;
    logic [15:0]   completer_id;
    logic          req_compl_wd;
    logic [31:0]   tx_reg_data;
    logic [2:0]    req_tc;
    logic          req_td;
    logic          req_ep;
    logic [1:0]    req_attr;
    logic [15:0]   req_rid;
    logic [7:0]    req_tag;
    logic [6:0]    req_addr;
    logic          compl_done;
    logic          rd_req;
    logic [31:0]   rd_addr;
    logic [9:0]    rd_len;
    logic          rd_req_ack;
    logic [7:0]    rd_tag;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int ack_cnt = 0;
    int exp_tag = 0;

    always #2 clk = ~clk;

    tx_engine dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .s_axis_tx_tdata  (tdata),
        .s_axis_tx_tkeep  (tkeep),
        .s_axis_tx_tlast  (tlast),
        .s_axis_tx_tvalid (tvalid),
        .s_axis_tx_tready (tready),
        .s_axis_tx_tuser  (tuser),
        .completer_id_i   (completer_id),
        .req_compl_wd_i   (req_compl_wd),
        .tx_reg_data_i    (tx_reg_data),
        .req_tc_i         (req_tc),
        .req_td_i         (req_td),
        .req_ep_i         (req_ep),
        .req_attr_i       (req_attr),
        .req_rid_i        (req_rid),
        .req_tag_i        (req_tag),
        .req_addr_i       (req_addr),
        .compl_done_o     (compl_done),
        .rd_req_i         (rd_req),
        .rd_addr_i        (rd_addr),
        .rd_len_i         (rd_len),
        .rd_req_ack_o     (rd_req_ack),
        .rd_tag_o         (rd_tag)
    );

    // Running pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (compl_done === 1'b1) done_cnt++;
        if (rd_req_ack === 1'b1) ack_cnt++;
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_mrd(input logic [31:0] a, input logic [9:0] l,
                                             input logic [7:0] t);
        logic [3:0] lbe;
        lbe = (l == 10'd1) ? 4'h0 : 4'hF;
        return {32'd0, a[31:2], 2'b00, 16'h0200, t, lbe, 4'hF, 22'd0, l};
    endfunction

    task automatic wait_tvalid(input string tag);
        int i;
        i = 0;
        while (tvalid !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        check_val({tag, "_tvalid"}, {127'd0, tvalid}, 128'd1);
    endtask

    task automatic set_cpl_a();
        tx_reg_data = 32'hDEADBEEF; req_tc = 3'd0; req_td = 1'b0; req_ep = 1'b0;
        req_attr = 2'b00; req_rid = 16'h0100; req_tag = 8'h05; req_addr = 7'h10;
    endtask

    task automatic set_cpl_b();
        tx_reg_data = 32'h12345678; req_tc = 3'd5; req_td = 1'b1; req_ep = 1'b1;
        req_attr = 2'b10; req_rid = 16'hABCD; req_tag = 8'hFF; req_addr = 7'h7F;
    endtask

    // Issue one MRd with tready high; expects it to carry exp_tag.
    task automatic run_mrd(input logic [31:0] a, input logic [9:0] l, input string tag);
        rd_addr = a; rd_len = l; rd_req = 1'b1;
        wait_tvalid(tag);
        check_val({tag, "_tdata"}, tdata, exp_mrd(a, l, 8'(exp_tag)));
        check_val({tag, "_tkeep"}, {112'd0, tkeep}, 128'h0FFF);
        @(negedge clk);
        check_val({tag, "_ack"}, {127'd0, rd_req_ack}, 128'd1);
        check_val({tag, "_rdtag"}, {120'd0, rd_tag}, 128'(exp_tag));
        rd_req = 1'b0;
        exp_tag = (exp_tag + 1) % TAG_MOD;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        int a0;
        rst_i = 1'b1; tready = 1'b0; completer_id = 16'h0200;
        req_compl_wd = 1'b0; rd_req = 1'b0; rd_addr = 32'd0; rd_len = 10'd0;
        set_cpl_a();
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        check_val("rst_tvalid", {127'd0, tvalid}, 128'd0);
        check_val("rst_done", {127'd0, compl_done}, 128'd0);
        check_val("rst_ack", {127'd0, rd_req_ack}, 128'd0);
        check_val("rst_tdata", tdata, 128'd0);
        check_val("rst_rdtag", {120'd0, rd_tag}, 128'd0);
        check_val("tuser", {124'd0, tuser}, 128'd0);

        // CplD from the plan; request held one cycle past the done pulse.
        tready = 1'b1; req_compl_wd = 1'b1;
        d0 = done_cnt;
        wait_tvalid("cpl");
        check_val("cpl_tdata", tdata, CPL_A);
        check_val("cpl_tkeep", {112'd0, tkeep}, 128'hFFFF);
        check_val("cpl_tlast", {127'd0, tlast}, 128'd1);
        @(negedge clk);
        check_val("cpl_done", {127'd0, compl_done}, 128'd1);
        check_val("cpl_drop", {127'd0, tvalid}, 128'd0);
        @(negedge clk);
        check_val("cpl_nodup", {127'd0, tvalid}, 128'd0);
        req_compl_wd = 1'b0;
        repeat (3) @(negedge clk);
        check_val("cpl_idle", {127'd0, tvalid}, 128'd0);
        check_val("cpl_done_cnt", 128'(done_cnt - d0), 128'd1);

        // Reset while an MRd is stalled; it is re-sent with tag 0.
        tready = 1'b0; rd_addr = 32'h2000_0008; rd_len = 10'd1; rd_req = 1'b1;
        a0 = ack_cnt;
        wait_tvalid("rmb");
        check_val("rmb_tdata", tdata, exp_mrd(32'h2000_0008, 10'd1, 8'd0));
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check_val("rmb_tvalid", {127'd0, tvalid}, 128'd0);
        check_val("rmb_ack", {127'd0, rd_req_ack}, 128'd0);
        rst_i = 1'b0; tready = 1'b1;
        run_mrd(32'h2000_0008, 10'd1, "rmb_resend");
        check_val("rmb_ack_cnt", 128'(ack_cnt - a0), 128'd1);

        // Idle reset returns the tag counter to 0, then the plan MRds.
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        exp_tag = 0;
        rd_addr = 32'h1000_0040; rd_len = 10'd32; rd_req = 1'b1;
        wait_tvalid("mrd0");
        check_val("mrd0_tdata", tdata, 128'h00000000_10000040_020000FF_00000020);
        rd_req = 1'b0;
        repeat (4) @(negedge clk);
        exp_tag = 1;
        run_mrd(32'h1000_0044, 10'd1, "mrd1");

        // Backpressure: beat stays stable while request fields change.
        tready = 1'b0; set_cpl_b(); req_compl_wd = 1'b1;
        wait_tvalid("bp");
        check_val("bp_tdata", tdata, CPL_B);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tx_reg_data = 32'h0BAD_0000 + 32'(i); req_tag = 8'(i);
            check_val("bp_hold_valid", {127'd0, tvalid}, 128'd1);
            check_val("bp_hold_data", tdata, CPL_B);
            check_val("bp_hold_done", {127'd0, compl_done}, 128'd0);
        end
        tready = 1'b1;
        @(negedge clk);
        check_val("bp_done", {127'd0, compl_done}, 128'd1);
        req_compl_wd = 1'b0;
        @(negedge clk);
        check_val("bp_done_low", {127'd0, compl_done}, 128'd0);
        @(negedge clk);

        // Simultaneous requests: CplD first, then MRd, one pulse each.
        set_cpl_a(); d0 = done_cnt; a0 = ack_cnt;
        rd_addr = 32'h0000_0100; rd_len = 10'd4;
        req_compl_wd = 1'b1; rd_req = 1'b1;
        wait_tvalid("sim_cpl");
        check_val("sim_cpl_tdata", tdata, CPL_A);
        @(negedge clk);
        check_val("sim_done", {127'd0, compl_done}, 128'd1);
        check_val("sim_no_ack", {127'd0, rd_req_ack}, 128'd0);
        req_compl_wd = 1'b0;
        @(negedge clk);
        check_val("sim_gap", {127'd0, tvalid}, 128'd0);
        run_mrd(32'h0000_0100, 10'd4, "sim_mrd");
        check_val("sim_done_cnt", 128'(done_cnt - d0), 128'd1);
        check_val("sim_ack_cnt", 128'(ack_cnt - a0), 128'd1);

        // Tag wrap with odd lengths (incl. 0 = 1024) and unaligned addresses.
        for (int i = 0; i < TAG_MOD + 1; i++) begin
            run_mrd(32'h8000_0003 + 32'(i * 4), 10'(i % 4), "wrap");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
